// File: rtl/instruction_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruction_loader_pkg
// Shared instruction definitions for the CICERO program loader:
//   - instruction word field positions (type in [19:16], data in [15:0],
//     reserved [31:20])
//   - INSTRUCTION_TYPE_COUNT: number of defined instruction types
//   - loader_state_t: loader FSM states
//   - load_error_t: error codes reported on error_code
//   - instr_type(): extracts the type field from a 32-bit instruction word
// -----------------------------------------------------------------------------
package instruction_loader_pkg;

    localparam int INSTRUCTION_TYPE_COUNT = 10;

    localparam int INSTR_DATA_LSB = 0;
    localparam int INSTR_DATA_MSB = 15;
    localparam int INSTR_TYPE_LSB = 16;
    localparam int INSTR_TYPE_MSB = 19;
    localparam int INSTR_RSVD_LSB = 20;
    localparam int INSTR_W        = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    typedef enum logic [1:0] {
        LOAD_OK       = 2'd0,
        LOAD_TRUNC    = 2'd1,
        LOAD_ILLEGAL  = 2'd2,
        LOAD_OVERFLOW = 2'd3
    } load_error_t;

    function automatic logic [3:0] instr_type(input logic [INSTR_W-1:0] word);
        return word[INSTR_TYPE_MSB:INSTR_TYPE_LSB];
    endfunction

endpackage

// File: rtl/instruction_checker.sv
// -----------------------------------------------------------------------------
// instruction_checker
// Combinational legality check of one 32-bit instruction word. A word is legal
// when its type field names a defined instruction (below
// INSTRUCTION_TYPE_COUNT) and its reserved bits [31:20] are zero.
// Only instantiated when INSTRUCTION_LOADER_CHECK_EN is defined.
// Ports:
//   word   in  32  assembled instruction word
//   legal  out 1   word may be written to instruction memory
// -----------------------------------------------------------------------------
import instruction_loader_pkg::*;

module instruction_checker (
    input  logic [INSTR_W-1:0] word,
    output logic               legal
);

    localparam logic [3:0] TYPE_MAX = 4'(INSTRUCTION_TYPE_COUNT - 1);

    logic [3:0] itype;
    logic       unused_data;

    assign itype       = instr_type(word);
    assign legal       = (itype <= TYPE_MAX) && (word[INSTR_W-1:INSTR_RSVD_LSB] == '0);
    // The data field carries no legality constraint.
    assign unused_data = ^word[INSTR_DATA_MSB:INSTR_DATA_LSB];

endmodule

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Streams a compiled regex program from the host byte channel into CICERO
// instruction memory. Four little-endian bytes form one 32-bit word, which is
// written to consecutive addresses starting at start_addr.
// Build option: INSTRUCTION_LOADER_CHECK_EN - when defined, every word is
// checked against the instruction encoding and an illegal word aborts the load
// with error code 2; when undefined every assembled word is written.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, start_addr     load request (IDLE only) and first write address
//   in_data/valid/last    program byte stream; in_ready accepts a byte
//   mem_we/addr/wdata     instruction-memory write port
//   busy                  load in progress (accepted start until IDLE)
//   done                  one-cycle pulse on successful completion
//   error, error_code     sticky error flag and cause (cleared by next start)
//   instr_count           words written in the current or last load
// -----------------------------------------------------------------------------
import instruction_loader_pkg::*;

module instruction_loader #(
    parameter int MEMORY_ADDR_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [MEMORY_ADDR_WIDTH-1:0] start_addr,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         mem_we,
    output logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
    output logic [INSTR_W-1:0]           mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   error_code,
    output logic [MEMORY_ADDR_WIDTH:0]   instr_count
);

    localparam logic [MEMORY_ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [MEMORY_ADDR_WIDTH:0]   COUNT_ONE = 1;

    loader_state_t        state, state_nxt;
    load_error_t          err_code;
    logic [1:0]           byte_idx;
    logic [INSTR_W-1:0]   word;
    logic                 last_seen;   // in_last arrived together with byte 3
    logic                 drained;     // program's final byte already consumed on entering ERROR
    logic                 legal;
    logic                 accept;
    logic                 addr_at_top;

`ifdef INSTRUCTION_LOADER_CHECK_EN
    instruction_checker u_checker (
        .word  (word),
        .legal (legal)
    );
`else
    assign legal = 1'b1;
`endif

    // Outputs depend on registered state only, never on in_valid.
    assign in_ready    = (state == LOAD) || ((state == ERROR) && !drained);
    assign mem_we      = (state == WRITE) && legal;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mem_wdata   = word;
    assign error_code  = err_code;
    assign accept      = in_valid && in_ready;
    assign addr_at_top = &mem_addr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (accept) begin
                    if (byte_idx == 2'd3)  state_nxt = WRITE;
                    else if (in_last)      state_nxt = ERROR;
                end
            end
            WRITE: begin
                if (!legal)            state_nxt = ERROR;
                else if (last_seen)    state_nxt = DONE;
                else if (addr_at_top)  state_nxt = ERROR;
                else                   state_nxt = LOAD;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERROR: begin
                if (drained || (accept && in_last)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            err_code    <= LOAD_OK;
            byte_idx    <= 2'd0;
            word        <= '0;
            last_seen   <= 1'b0;
            drained     <= 1'b0;
            mem_addr    <= '0;
            instr_count <= '0;
            error       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr    <= start_addr;
                        byte_idx    <= 2'd0;
                        word        <= '0;
                        last_seen   <= 1'b0;
                        drained     <= 1'b0;
                        instr_count <= '0;
                        error       <= 1'b0;
                        err_code    <= LOAD_OK;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word[8*byte_idx +: 8] <= in_data;
                        byte_idx              <= byte_idx + 2'd1;   // wraps 3 -> 0 for the next word
                        last_seen             <= in_last;
                        if (in_last && (byte_idx != 2'd3)) begin
                            error    <= 1'b1;
                            err_code <= LOAD_TRUNC;
                            drained  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (!legal) begin
                        error    <= 1'b1;
                        err_code <= LOAD_ILLEGAL;
                        drained  <= last_seen;
                    end else begin
                        mem_addr    <= mem_addr + ADDR_ONE;
                        instr_count <= instr_count + COUNT_ONE;
                        // A wrapped write with more program to come cannot continue.
                        if (!last_seen && addr_at_top) begin
                            error    <= 1'b1;
                            err_code <= LOAD_OVERFLOW;
                            drained  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
